// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table: 2-bit counters, tags and targets, with a
// registered fetch prediction and a registered mispredict/redirect from execute.
module branch_predictor_bht #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_req_i,
    input  logic [31:0]      pred_pc_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    input  logic             upd_valid_i,
    input  logic             upd_is_b_type_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [31:0]      upd_pred_tgt_i,
    output logic             mispredict_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0] valid_r;
    logic [1:0]         ctr_r    [ENTRIES];
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];

    logic [IDX_BITS-1:0] pred_idx_s;
    logic [TAG_W-1:0]    pred_tag_s;
    logic                pred_hit_s;
    logic                pred_taken_s;
    logic [31:0]         pred_target_s;
    logic [IDX_BITS-1:0] upd_idx_s;
    logic [TAG_W-1:0]    upd_tag_s;
    logic                upd_hit_s;
    logic                train_s;
    logic                mispred_s;
    logic [31:0]         redirect_s;

    // Table lookup for fetch and for the resolving branch
    always_comb begin
        pred_idx_s    = pred_pc_i[IDX_BITS+1:2];
        pred_tag_s    = pred_pc_i[31:IDX_BITS+2];
        pred_hit_s    = valid_r[pred_idx_s] && (tag_r[pred_idx_s] == pred_tag_s);
        pred_taken_s  = pred_hit_s && ctr_r[pred_idx_s][1];
        pred_target_s = pred_pc_i + 32'd4;
        if (pred_taken_s) begin
            pred_target_s = target_r[pred_idx_s];
        end else begin
            pred_target_s = pred_pc_i + 32'd4;
        end
        upd_idx_s  = upd_pc_i[IDX_BITS+1:2];
        upd_tag_s  = upd_pc_i[31:IDX_BITS+2];
        upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        train_s    = upd_valid_i && upd_is_b_type_i;
        mispred_s  = train_s && ((upd_taken_i != upd_pred_taken_i) ||
                                 (upd_taken_i && (upd_pred_tgt_i != upd_target_i)));
        redirect_s = upd_pc_i + 32'd4;
        if (upd_taken_i) begin
            redirect_s = upd_target_i;
        end else begin
            redirect_s = upd_pc_i + 32'd4;
        end
    end

    // Valid bits and counters; a miss-taken allocates weakly taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (train_s) begin
            case ({upd_hit_s, upd_taken_i})
                2'b11:   ctr_r[upd_idx_s] <= sat_inc(ctr_r[upd_idx_s]);
                2'b10:   ctr_r[upd_idx_s] <= sat_dec(ctr_r[upd_idx_s]);
                2'b01: begin
                    valid_r[upd_idx_s] <= 1'b1;
                    ctr_r[upd_idx_s]   <= 2'b10;
                end
                default: ctr_r[upd_idx_s] <= ctr_r[upd_idx_s];
            endcase
        end
    end

    // Tags and targets carry no reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (train_s && upd_taken_i) begin
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= upd_target_i;
        end
    end

    // Registered prediction; taken/target hold when there is no request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= 32'd0;
        end else if (pred_req_i) begin
            pred_valid_o  <= 1'b1;
            pred_taken_o  <= pred_taken_s;
            pred_target_o <= pred_target_s;
        end else begin
            pred_valid_o  <= 1'b0;
        end
    end

    // Registered mispredict pulse, redirect PC and wrapping statistics counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= 32'd0;
            mispred_cnt_o <= '0;
        end else if (mispred_s) begin
            mispredict_o  <= 1'b1;
            redirect_pc_o <= redirect_s;
            mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end else begin
            mispredict_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized bench for branch_predictor_bht against a per-entry behavioural
// model of the history table, plus directed reset/alias/collision scenarios.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pred_req_i;
    logic [31:0] pred_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic        upd_is_b_type_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic [31:0] upd_pred_tgt_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] mispred_cnt_o;

    branch_predictor_bht #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o),
        .upd_valid_i(upd_valid_i), .upd_is_b_type_i(upd_is_b_type_i),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
        .upd_pred_tgt_i(upd_pred_tgt_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one record per entry, counter kept as an integer 0..3
    bit          m_valid [64];
    int          m_ctr   [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];

    logic        exp_pv, exp_pt, exp_mp;
    logic [31:0] exp_ptgt, exp_rpc, exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        exp_pv = 1'b0; exp_pt = 1'b0; exp_ptgt = 32'd0;
        exp_mp = 1'b0; exp_rpc = 32'd0; exp_cnt = 32'd0;
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]);
    endfunction

    task automatic check_all(input string where);
        check({where, ".pred_valid"}, {31'd0, pred_valid_o}, {31'd0, exp_pv});
        check({where, ".pred_taken"}, {31'd0, pred_taken_o}, {31'd0, exp_pt});
        check({where, ".pred_target"}, pred_target_o, exp_ptgt);
        check({where, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, exp_mp});
        check({where, ".redirect_pc"}, redirect_pc_o, exp_rpc);
        check({where, ".mispred_cnt"}, mispred_cnt_o, exp_cnt);
    endtask

    task automatic step(input string where, input logic req, input logic [31:0] pc,
                        input logic uv, input logic ub, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt,
                        input logic upt, input logic [31:0] uptgt);
        int k;
        pred_req_i = req; pred_pc_i = pc;
        upd_valid_i = uv; upd_is_b_type_i = ub; upd_pc_i = upc;
        upd_taken_i = ut; upd_target_i = utgt;
        upd_pred_taken_i = upt; upd_pred_tgt_i = uptgt;
        // Prediction is taken from the table as it stands before this edge
        if (req) begin
            exp_pv   = 1'b1;
            exp_pt   = model_hit(pc) && (m_ctr[pc[7:2]] >= 2);
            exp_ptgt = exp_pt ? m_tgt[pc[7:2]] : pc + 32'd4;
        end else begin
            exp_pv = 1'b0;
        end
        exp_mp = uv && ub && ((ut != upt) || (ut && (uptgt != utgt)));
        if (exp_mp) begin
            exp_rpc = ut ? utgt : upc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
        end
        if (uv && ub) begin
            k = int'(upc[7:2]);
            if (model_hit(upc)) begin
                if (ut) begin
                    m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                    m_tgt[k] = utgt;
                end else begin
                    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (ut) begin
                m_valid[k] = 1'b1;
                m_tag[k]   = upc[31:8];
                m_tgt[k]   = utgt;
                m_ctr[k]   = 2;
            end
        end
        @(posedge clk);
        #1;
        check_all(where);
        @(negedge clk);
    endtask

    task automatic req(input string where, input logic [31:0] pc);
        step(where, 1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic upd(input string where, input logic [31:0] pc, input logic t,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        step(where, 1'b0, 32'd0, 1'b1, 1'b1, pc, t, tgt, pt, ptgt);
    endtask

    initial begin
        logic [31:0] rpc, rtgt;
        reset_n = 1'b0;
        pred_req_i = 1'b0; pred_pc_i = 32'd0;
        upd_valid_i = 1'b0; upd_is_b_type_i = 1'b0; upd_pc_i = 32'd0;
        upd_taken_i = 1'b0; upd_target_i = 32'd0;
        upd_pred_taken_i = 1'b0; upd_pred_tgt_i = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // T1 cold lookup
        req("t1", 32'h100);
        check("t1.target_const", pred_target_o, 32'h104);
        // T2 allocation with a mispredict
        upd("t2.upd", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check("t2.redirect_const", redirect_pc_o, 32'h80);
        check("t2.cnt_const", mispred_cnt_o, 32'd1);
        req("t2.req", 32'h100);
        check("t2.taken_const", {31'd0, pred_taken_o}, 32'd1);
        // T4 alias on the same index
        req("t4", 32'h1100);
        check("t4.target_const", pred_target_o, 32'h1104);
        // T3 saturation walk
        for (int i = 0; i < 3; i++) upd("t3.inc", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        req("t3.sat", 32'h100);
        for (int i = 0; i < 3; i++) begin
            upd("t3.dec", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
            req("t3.req", 32'h100);
        end
        check("t3.nt_const", pred_target_o, 32'h104);
        // T5 non-branch resolution leaves everything alone
        step("t5", 1'b0, 32'd0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h999, 1'b0, 32'd0);
        req("t5.req", 32'h100);
        // T6 read-before-write on a shared index, then reset mid-pulse
        upd("t6.alloc", 32'h200, 1'b1, 32'h300, 1'b1, 32'h300);
        step("t6.coll", 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
        check("t6.old_entry", {31'd0, pred_taken_o}, 32'd1);
        req("t6.after", 32'h200);
        upd("t6.pulse", 32'h204, 1'b1, 32'h40, 1'b0, 32'h208);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.reset");
        @(negedge clk);
        reset_n = 1'b1;
        req("t6.cleared", 32'h200);

        // Randomized traffic over a small set of aliasing PCs
        for (int n = 0; n < 600; n++) begin
            rpc  = ({22'd0, 10'($urandom_range(0, 2))} << 8) | ({26'd0, 6'($urandom_range(0, 3))} << 2);
            rtgt = {20'd0, 12'($urandom_range(0, 15)) << 4};
            step("rand", 1'($urandom), rpc,
                 1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ({22'd0, 10'($urandom_range(0, 2))} << 8) | ({26'd0, 6'($urandom_range(0, 3))} << 2),
                 1'($urandom), rtgt,
                 1'($urandom), ($urandom_range(0, 1) == 0) ? rtgt : 32'h40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
